// File: rtl/prog_seq_ctrl_if.sv
// Issue channel between the sequencer and the datapath: one instruction
// per valid/ready handshake.
interface prog_seq_ctrl_if #(
  parameter int FIELD_W = 4
);
  logic               issue_valid;
  logic               issue_ready;
  logic [FIELD_W-1:0] issue_op;
  logic [FIELD_W-1:0] issue_rs1;
  logic [FIELD_W-1:0] issue_rs2;
  logic [FIELD_W-1:0] issue_wr;

  modport master (
    output issue_valid, issue_op, issue_rs1, issue_rs2, issue_wr,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_op, issue_rs1, issue_rs2, issue_wr,
    output issue_ready
  );
endinterface

// File: rtl/prog_seq_ctrl.sv
// Button-driven instruction entry sequencer: debounced field entry, single
// instruction execute, and a small program buffer replayed over the issue channel.
module prog_seq_ctrl #(
  parameter int FIELD_W    = 4,
  parameter int DEPTH      = 8,
  parameter int DEB_CYCLES = 16
) (
  input  logic                       clk_ref,
  input  logic                       rst,
  input  logic [FIELD_W-1:0]         sw,
  input  logic                       btn_next,
  input  logic                       btn_run,
  input  logic                       btn_show,
  input  logic                       mode,
  input  logic                       clr,
  prog_seq_ctrl_if.master            iss,
  output logic [2:0]                 state,
  output logic [$clog2(DEPTH):0]     prog_cnt,
  output logic [$clog2(DEPTH)-1:0]   step_idx,
  output logic                       full,
  output logic                       ovf,
  output logic                       show_instr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int IW = 4 * FIELD_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OP   = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_WR   = 3'd4,
    S_EXEC = 3'd5,
    S_DONE = 3'd6,
    S_RUN  = 3'd7
  } state_e;

  // ---------------- button conditioning: {show, run, next}
  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]    deb_lvl_q, deb_lvl_d, press_q, press_d;
  logic [DW-1:0] deb_cnt_q [3];
  logic [DW-1:0] deb_cnt_d [3];

  assign btn_raw = {btn_show, btn_run, btn_next};

  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    deb_lvl_d = deb_lvl_q;
    press_d   = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      deb_cnt_d[i] = '0;
      // the counter tracks a run of samples disagreeing with the accepted level
      if (sync2_q[i] != deb_lvl_q[i]) begin
        if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) deb_lvl_d[i] = sync2_q[i];
        else                                     deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
      end
      press_d[i] = deb_lvl_d[i] & ~deb_lvl_q[i];
    end
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_lvl_q <= '0;
      press_q   <= '0;
      for (int unsigned i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_lvl_q <= deb_lvl_d;
      press_q   <= press_d;
      for (int unsigned i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  logic press_next, press_run, show_lvl;
  assign press_next = press_q[0];
  assign press_run  = press_q[1];
  assign show_lvl   = deb_lvl_q[2];

  // ---------------- sequencer
  state_e             state_q, state_d;
  logic [FIELD_W-1:0] op_q, op_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [IW-1:0]      iss_q, iss_d;
  logic [CW-1:0]      prog_cnt_q, prog_cnt_d;
  logic [AW-1:0]      step_q, step_d;
  logic               ovf_q, ovf_d;
  logic               mem_we;
  logic [IW-1:0]      mem_wdata;
  logic [IW-1:0]      prog_mem [DEPTH];

  assign full = (prog_cnt_q == CW'(DEPTH));

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    iss_d      = iss_q;
    prog_cnt_d = prog_cnt_q;
    step_d     = step_q;
    ovf_d      = ovf_q;
    mem_we     = 1'b0;
    mem_wdata  = {op_q, rs1_q, rs2_q, sw};
    case (state_q)
      S_IDLE: begin
        if (clr) begin
          prog_cnt_d = '0;
          ovf_d      = 1'b0;
        end
        // a run request racing a clear is dropped so RUN never sees an empty buffer
        if (press_next) begin
          state_d = S_OP;
        end else if (press_run && !clr && (prog_cnt_q != '0)) begin
          state_d = S_RUN;
          step_d  = '0;
          iss_d   = prog_mem[0];
        end
      end
      S_OP:  if (press_next) begin op_d  = sw; state_d = S_RD1; end
      S_RD1: if (press_next) begin rs1_d = sw; state_d = S_RD2; end
      S_RD2: if (press_next) begin rs2_d = sw; state_d = S_WR;  end
      S_WR: begin
        if (press_next) begin
          if (!mode) begin
            iss_d   = {op_q, rs1_q, rs2_q, sw};
            state_d = S_EXEC;
          end else if (!full) begin
            mem_we     = 1'b1;
            prog_cnt_d = prog_cnt_q + CW'(1);
            state_d    = S_OP;
          end else begin
            ovf_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_EXEC: if (iss.issue_ready) state_d = S_DONE;
      S_RUN: begin
        // the next entry is preloaded on each handshake so issue runs back-to-back
        if (iss.issue_ready) begin
          step_d = step_q + AW'(1);
          if ({1'b0, step_q} == prog_cnt_q - CW'(1)) state_d = S_DONE;
          else                                       iss_d   = prog_mem[step_q + AW'(1)];
        end
      end
      S_DONE:  if (press_next) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      iss_q      <= '0;
      prog_cnt_q <= '0;
      step_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      iss_q      <= iss_d;
      prog_cnt_q <= prog_cnt_d;
      step_q     <= step_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk_ref) begin
    if (mem_we) prog_mem[prog_cnt_q[AW-1:0]] <= mem_wdata;
  end

  assign iss.issue_valid = (state_q == S_EXEC) || (state_q == S_RUN);
  assign {iss.issue_op, iss.issue_rs1, iss.issue_rs2, iss.issue_wr} = iss_q;

  assign state      = state_q;
  assign prog_cnt   = prog_cnt_q;
  assign step_idx   = step_q;
  assign ovf        = ovf_q;
  assign show_instr = (state_q == S_DONE) && show_lvl;
endmodule

// File: tb/tb_prog_seq_ctrl.sv
// Bench for prog_seq_ctrl: directed vectors and corner sequences, then random
// button traffic checked against a queue-based model of the sequencer.
module tb_prog_seq_ctrl;
  localparam int FW    = 4;
  localparam int DEPTH = 8;
  localparam int DEB   = 4;
  localparam int AW    = 3;

  logic          clk_ref = 1'b0;
  logic          rst;
  logic [FW-1:0] sw;
  logic          btn_next, btn_run, btn_show, mode, clr;
  logic [2:0]    state;
  logic [AW:0]   prog_cnt;
  logic [AW-1:0] step_idx;
  logic          full, ovf, show_instr;

  prog_seq_ctrl_if #(.FIELD_W(FW)) bus ();

  prog_seq_ctrl #(.FIELD_W(FW), .DEPTH(DEPTH), .DEB_CYCLES(DEB)) dut (
    .clk_ref(clk_ref), .rst(rst), .sw(sw), .btn_next(btn_next), .btn_run(btn_run),
    .btn_show(btn_show), .mode(mode), .clr(clr), .iss(bus), .state(state),
    .prog_cnt(prog_cnt), .step_idx(step_idx), .full(full), .ovf(ovf),
    .show_instr(show_instr)
  );

  always #5 clk_ref = ~clk_ref;

  int tests = 0;
  int fails = 0;
  bit rnd_ready = 1'b0;

  // handshake log, written only by the monitor
  logic [15:0] got_q[$];
  int          valid_cycles = 0;
  always @(negedge clk_ref) begin
    if (bus.issue_valid) valid_cycles++;
    if (bus.issue_valid && bus.issue_ready)
      got_q.push_back({bus.issue_op, bus.issue_rs1, bus.issue_rs2, bus.issue_wr});
  end

  // reference model
  int          m_state;
  logic [15:0] m_cur;
  logic [15:0] m_prog[$];
  logic [15:0] exp_q[$];
  bit          m_ovf;

  typedef struct {
    logic [FW-1:0] op, rs1, rs2, wr;
    logic [15:0]   exp_iss;
    int            exp_vcycles;
    logic [2:0]    exp_state;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ref);
    #2;
    if (rnd_ready) bus.issue_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       btn_next = v;
      1:       btn_run  = v;
      default: btn_show = v;
    endcase
  endtask

  task automatic press(input int b, input logic [FW-1:0] s);
    sw = s;
    set_btn(b, 1'b1);
    repeat (DEB + 4) tick();
    set_btn(b, 1'b0);
    repeat (DEB + 4) tick();
  endtask

  task automatic enter4(input logic [15:0] ins);
    press(0, ins[15:12]);
    press(0, ins[11:8]);
    press(0, ins[7:4]);
    press(0, ins[3:0]);
  endtask

  task automatic do_reset();
    btn_next = 0; btn_run = 0; btn_show = 0; clr = 0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 8 * DEB + 16 && !bus.issue_valid; i++) tick();
    chk("wait_valid", 32'(bus.issue_valid), 32'd1);
  endtask

  task automatic settle();
    for (int i = 0; i < 400 && bus.issue_valid; i++) tick();
    chk("settle", 32'(bus.issue_valid), 32'd0);
  endtask

  task automatic model_next(input logic [FW-1:0] s, input logic m);
    case (m_state)
      0: m_state = 1;
      1: begin m_cur[15:12] = s; m_state = 2; end
      2: begin m_cur[11:8]  = s; m_state = 3; end
      3: begin m_cur[7:4]   = s; m_state = 4; end
      4: begin
        m_cur[3:0] = s;
        if (!m) begin
          exp_q.push_back(m_cur);
          m_state = 6;
        end else if (m_prog.size() < DEPTH) begin
          m_prog.push_back(m_cur);
          m_state = 1;
        end else begin
          m_ovf   = 1'b1;
          m_state = 0;
        end
      end
      6: m_state = 0;
      default: ;
    endcase
  endtask

  task automatic model_run();
    if (m_state == 0 && m_prog.size() > 0) begin
      foreach (m_prog[i]) exp_q.push_back(m_prog[i]);
      m_state = 6;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          p0, vc0, rd, nexp, r;
    logic [15:0] f0;
    logic [FW-1:0] s;
    logic        m;

    rst = 1'b1; sw = '0; mode = 0; clr = 0;
    btn_next = 0; btn_run = 0; btn_show = 0;
    bus.issue_ready = 1'b0;
    do_reset();

    // reset values
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_prog_cnt", 32'(prog_cnt), 32'd0);
    chk("rst_step", 32'(step_idx), 32'd0);
    chk("rst_valid", 32'(bus.issue_valid), 32'd0);
    chk("rst_fields", 32'({bus.issue_op, bus.issue_rs1, bus.issue_rs2, bus.issue_wr}), 32'd0);
    chk("rst_flags", 32'({full, ovf, show_instr}), 32'd0);

    // single-instruction vectors
    vt[0] = '{4'd1,  4'd0,  4'd5,  4'd1,  16'h1051, 1, 3'd6};
    vt[1] = '{4'd15, 4'd15, 4'd15, 4'd15, 16'hFFFF, 1, 3'd6};
    vt[2] = '{4'd0,  4'd0,  4'd0,  4'd0,  16'h0000, 1, 3'd6};
    vt[3] = '{4'd10, 4'd3,  4'd12, 4'd6,  16'hA3C6, 1, 3'd6};
    mode = 1'b0;
    bus.issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vc0 = valid_cycles;
      p0  = got_q.size();
      press(0, 4'd0);
      enter4({vt[i].op, vt[i].rs1, vt[i].rs2, vt[i].wr});
      chk("vec_state", 32'(state), 32'(vt[i].exp_state));
      chk("vec_vcycles", 32'(valid_cycles - vc0), 32'(vt[i].exp_vcycles));
      chk("vec_hs_count", 32'(got_q.size() - p0), 32'd1);
      if (got_q.size() > p0) chk("vec_issued", 32'(got_q[p0]), 32'(vt[i].exp_iss));
      chk("vec_hold", 32'({bus.issue_op, bus.issue_rs1, bus.issue_rs2, bus.issue_wr}),
          32'(vt[i].exp_iss));
      press(0, 4'd0);
      chk("vec_back_idle", 32'(state), 32'd0);
    end

    // debounce: short glitch ignored, long press advances once
    btn_next = 1'b1;
    repeat (DEB - 1) tick();
    btn_next = 1'b0;
    repeat (2 * DEB + 6) tick();
    chk("glitch_state", 32'(state), 32'd0);
    press(0, 4'd0);
    chk("press_once", 32'(state), 32'd1);

    // show request in DONE only
    press(0, 4'd1); press(0, 4'd2); press(0, 4'd3); press(0, 4'd4);
    chk("show_done", 32'(state), 32'd6);
    btn_show = 1'b1;
    repeat (DEB + 4) tick();
    chk("show_on", 32'(show_instr), 32'd1);
    btn_show = 1'b0;
    repeat (DEB + 4) tick();
    chk("show_off", 32'(show_instr), 32'd0);
    press(0, 4'd0);
    btn_show = 1'b1;
    repeat (DEB + 4) tick();
    chk("show_idle", 32'(show_instr), 32'd0);
    btn_show = 1'b0;
    repeat (DEB + 4) tick();

    // program entry, then run back-to-back
    do_reset();
    mode = 1'b1;
    press(0, 4'd0);
    enter4(16'hA123); enter4(16'hB123); enter4(16'hE132);
    chk("prog_cnt3", 32'(prog_cnt), 32'd3);
    chk("prog_state_op", 32'(state), 32'd1);
    mode = 1'b0;
    enter4(16'h0000);
    press(0, 4'd0);
    chk("prog_idle", 32'(state), 32'd0);
    f0 = 16'hA123;
    btn_run = 1'b1;
    wait_valid();
    for (int k = 0; k < 3; k++) begin
      chk("run_valid", 32'(bus.issue_valid), 32'd1);
      chk("run_step", 32'(step_idx), 32'(k));
      chk("run_fields", 32'({bus.issue_op, bus.issue_rs1, bus.issue_rs2, bus.issue_wr}),
          32'((k == 0) ? 16'hA123 : (k == 1) ? 16'hB123 : 16'hE132));
      tick();
    end
    chk("run_done", 32'(state), 32'd6);
    chk("run_cnt_kept", 32'(prog_cnt), 32'd3);
    btn_run = 1'b0;
    repeat (DEB + 4) tick();
    press(0, 4'd0);

    // backpressure 0,0,1 then reset mid-run at step 1
    bus.issue_ready = 1'b0;
    btn_run = 1'b1;
    wait_valid();
    chk("bp_step0", 32'(step_idx), 32'd0);
    chk("bp_f0", 32'({bus.issue_op, bus.issue_rs1, bus.issue_rs2, bus.issue_wr}), 32'(f0));
    tick();
    chk("bp_stall1_step", 32'(step_idx), 32'd0);
    chk("bp_stall1_f", 32'({bus.issue_op, bus.issue_rs1, bus.issue_rs2, bus.issue_wr}), 32'(f0));
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    chk("bp_step1", 32'(step_idx), 32'd1);
    chk("bp_f1", 32'({bus.issue_op, bus.issue_rs1, bus.issue_rs2, bus.issue_wr}), 32'h0000B123);
    btn_run = 1'b0;
    tick();
    chk("bp_hold_step1", 32'(step_idx), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_valid", 32'(bus.issue_valid), 32'd0);
    chk("arst_prog_cnt", 32'(prog_cnt), 32'd0);
    #2 rst = 1'b0;
    repeat (DEB + 4) tick();

    // overflow and clear
    bus.issue_ready = 1'b1;
    mode = 1'b1;
    press(0, 4'd0);
    for (int i = 0; i < 8; i++) enter4(16'(i * 16'h1111));
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_cnt8", 32'(prog_cnt), 32'd8);
    chk("ovf_not_yet", 32'(ovf), 32'd0);
    enter4(16'h9999);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_idle", 32'(state), 32'd0);
    chk("ovf_cnt_kept", 32'(prog_cnt), 32'd8);
    clr = 1'b1; tick(); clr = 1'b0; tick();
    chk("clr_cnt", 32'(prog_cnt), 32'd0);
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_full", 32'(full), 32'd0);

    // random traffic against the model
    do_reset();
    m_state = 0; m_ovf = 1'b0; m_cur = '0;
    m_prog.delete(); exp_q.delete();
    rd = got_q.size();
    rnd_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        s    = FW'($urandom);
        m    = ($urandom_range(0, 3) != 0);
        mode = m;
        press(0, s);
        model_next(s, m);
      end else if (r < 85) begin
        press(1, FW'($urandom));
        model_run();
      end else if (r < 93) begin
        clr = 1'b1; tick(); clr = 1'b0; tick();
        if (m_state == 0) begin m_prog.delete(); m_ovf = 1'b0; end
      end else begin
        press(2, FW'($urandom));
      end
      settle();
      chk("rnd_state", 32'(state), 32'(m_state));
      chk("rnd_prog_cnt", 32'(prog_cnt), 32'(m_prog.size()));
      chk("rnd_ovf", 32'(ovf), 32'(m_ovf));
      chk("rnd_full", 32'(full), 32'(m_prog.size() == DEPTH));
      nexp = exp_q.size();
      chk("rnd_hs_count", 32'(got_q.size() - rd), 32'(nexp));
      for (int j = 0; j < nexp; j++) begin
        f0 = exp_q.pop_front();
        if (rd < got_q.size()) chk("rnd_issued", 32'(got_q[rd]), 32'(f0));
        rd++;
      end
      rd = got_q.size();
    end
    rnd_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/prog_seq_ctrl.md
PROG_SEQ_CTRL -- requirements
Module: prog_seq_ctrl

Interface
REQ-001 The block SHALL have parameter FIELD_W, default 4, giving the width of each instruction field (op, rs1, rs2, wr).
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of program-buffer entries (power of two, >=2).
REQ-003 The block SHALL have parameter DEB_CYCLES, default 16, giving the number of stable samples required to accept a button level.
REQ-004 clk_ref  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 sw  in  FIELD_W  field entry switches, sampled at an accepted press.
REQ-007 btn_next  in  1  raw button: advance / confirm.
REQ-008 btn_run  in  1  raw button: execute stored program.
REQ-009 btn_show  in  1  raw button: show executed instruction in DONE.
REQ-010 mode  in  1  0 = single-instruction execute, 1 = program entry into buffer.
REQ-011 clr  in  1  synchronous buffer clear, honoured in IDLE only.
REQ-012 issue_ready  in  1  datapath accepts the presented instruction.
REQ-013 issue_valid  out  1  instruction presented to the datapath.
REQ-014 issue_op, issue_rs1, issue_rs2, issue_wr  out  FIELD_W each  presented instruction fields.
REQ-015 state  out  3  FSM state code.
REQ-016 prog_cnt  out  $clog2(DEPTH)+1  number of stored instructions.
REQ-017 step_idx  out  $clog2(DEPTH)  buffer index being issued in RUN.
REQ-018 full, ovf, show_instr  out  1 each  buffer full, sticky overflow flag, display-instruction request.

Function
REQ-019 Each raw button SHALL pass through a 2-FF synchronizer and a debouncer that changes its level only after DEB_CYCLES consecutive equal samples; a 0->1 transition of the debounced level SHALL give exactly one 1-cycle press pulse.
REQ-020 The FSM states SHALL be IDLE=0, OP=1, RD1=2, RD2=3, WR=4, EXEC=5, DONE=6, RUN=7.
REQ-021 IDLE: a next press SHALL go to OP; a run press with prog_cnt>0 SHALL go to RUN with step_idx=0; a run press with prog_cnt=0 SHALL be ignored; if next and run presses coincide, next SHALL win.
REQ-022 In OP, RD1 and RD2, a next press SHALL latch sw into op, rs1 and rs2 respectively and advance to the following state.
REQ-023 In WR, a next press SHALL latch sw into wr, then act according to mode (REQ-024, REQ-025).
REQ-024 WR with mode=0 SHALL go to EXEC.
REQ-025 WR with mode=1 and prog_cnt<DEPTH SHALL write {op,rs1,rs2,wr} into buffer[prog_cnt], increment prog_cnt and go to OP; with prog_cnt=DEPTH it SHALL discard the entry, set ovf and go to IDLE.
REQ-026 EXEC SHALL hold issue_valid=1 with the latched fields stable until a cycle where issue_ready=1, then go to DONE the next cycle.
REQ-027 RUN SHALL present buffer[step_idx]; on each issue_valid&&issue_ready step_idx SHALL increment; the handshake on index prog_cnt-1 SHALL go to DONE; buffer contents and prog_cnt SHALL be retained for re-run.
REQ-028 Back-to-back handshakes in RUN SHALL be supported, one instruction per cycle when issue_ready is held 1.
REQ-029 DONE: show_instr SHALL equal the debounced btn_show level; the issue_* fields SHALL hold the last issued instruction; a next press SHALL go to IDLE.
REQ-030 issue_valid SHALL be 0 in every state except EXEC and RUN.
REQ-031 Presses in EXEC and RUN, and run presses outside IDLE, SHALL be ignored.
REQ-032 clr in IDLE SHALL zero prog_cnt and ovf in 1 cycle; clr in other states SHALL be ignored.
REQ-033 full SHALL equal (prog_cnt==DEPTH) combinationally from registered prog_cnt.

Reset
REQ-034 rst SHALL asynchronously force state=IDLE, prog_cnt=0, step_idx=0, issue_valid=0, issue_* fields=0, ovf=0, show_instr=0, and clear the debouncer and synchronizer registers to 0, including when rst is asserted mid-EXEC or mid-RUN.
REQ-035 Buffer RAM contents SHALL NOT need reset.

Verification
REQ-036 Single mode: mode=0, enter op=1, rs1=0, rs2=5, wr=1, issue_ready=1 -> exactly one issue_valid cycle carrying {1,0,5,1}, then state=6.
REQ-037 Debounce: a btn_next glitch of DEB_CYCLES-1 cycles -> no state change; a press of DEB_CYCLES+4 cycles -> exactly one advance.
REQ-038 Program mode: store {10,1,2,3},{11,1,2,3},{14,1,3,2}, run with issue_ready=1 -> 3 consecutive issue cycles in order, step_idx 0,1,2, then DONE with prog_cnt=3.
REQ-039 Backpressure: in RUN, issue_ready toggles 0,0,1 -> fields stable while stalled, step_idx advances only on the handshake.
REQ-040 Overflow: DEPTH=8, enter 9 instructions -> full=1 after the 8th, ovf=1 and state=0 after the 9th; clr in IDLE -> prog_cnt=0, ovf=0.
REQ-041 rst during RUN at step_idx=1 -> state=0, issue_valid=0 and prog_cnt=0 immediately, without waiting for a clock edge.
